// File: rtl/fpu_pkg.sv
// Shared FPU definitions: normalizer state encoding, float type coding,
// per-format exponent bias / saturation limit / fraction width, and the
// bit positions of the {N,Z,C,V} flag bus.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } norm_state_t;

    localparam logic FLOAT_HALF   = 1'b0;
    localparam logic FLOAT_SINGLE = 1'b1;

    localparam int BIAS_SINGLE   = 127;
    localparam int BIAS_HALF     = 15;
    localparam int EMAX_SINGLE   = 255;
    localparam int EMAX_HALF     = 31;
    localparam int FRAC_W_SINGLE = 23;
    localparam int FRAC_W_HALF   = 10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/fpu_normalizer_if.sv
// Handshake bundle between the FPU datapath and the post-normalize stage.
// The normalizer uses the slave modport; the raw-operand producer (and the
// result consumer) sit on the master side.
interface fpu_normalizer_if #(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              in_type;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [3:0]        out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_type, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_type, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fpu_rounder.sv
// Combinational fraction rounder for the normalizer's ROUND state.
// Build option FPU_NORM_RNE_EN: when defined, round-to-nearest-even;
// otherwise the fraction is truncated. Inexact is reported either way.
// Half-precision fractions arrive right-aligned in the low 10 bits.
module fpu_rounder
    import fpu_pkg::*;
(
    input  logic [22:0] frac,
    input  logic        guard,
    input  logic        sticky,
    input  logic        ftype,
    output logic [22:0] frac_out,
    output logic        carry,
    output logic        inexact
);

    logic        inc;
    logic [23:0] sum;

    // Decide the increment, detect carry-out at the format's width, wrap frac to 0 on carry.
    always_comb begin
        inc = 1'b0;
`ifdef FPU_NORM_RNE_EN
        inc = guard & (sticky | frac[0]);
`endif
        sum     = {1'b0, frac} + {23'd0, inc};
        carry   = (ftype == FLOAT_SINGLE) ? sum[23] : sum[10];
        if (carry) begin
            frac_out = '0;
        end else if (ftype == FLOAT_SINGLE) begin
            frac_out = sum[22:0];
        end else begin
            frac_out = {13'd0, sum[9:0]};
        end
        inexact = guard | sticky;
    end

endmodule

// File: rtl/fpu_normalizer.sv
// Multi-cycle post-normalize / round / pack stage. Shifts the raw mantissa
// one bit per cycle until the hidden bit sits at MANT_W-2, rounds through
// fpu_rounder, then packs a half or single word with {N,Z,C,V} flags.
// Build option FPU_NORM_RNE_EN (handled inside fpu_rounder) selects
// round-to-nearest-even instead of truncation.
// The interface instance must use the same MANT_W/EXP_W as this module.
module fpu_normalizer
    import fpu_pkg::*;
#(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10
) (
    input  logic             clk,
    input  logic             reset,
    fpu_normalizer_if.slave  bus
);

    localparam int OVF = MANT_W - 1;
    localparam int HID = MANT_W - 2;
    localparam int FTOP = MANT_W - 3;

    localparam logic signed [EXP_W-1:0] EMAX_S = EXP_W'(EMAX_SINGLE);
    localparam logic signed [EXP_W-1:0] EMAX_H = EXP_W'(EMAX_HALF);

    norm_state_t state;
    norm_state_t next_state;

    logic                     sign_r;
    logic signed [EXP_W-1:0]  exp_r;
    logic [MANT_W-1:0]        mant_r;
    logic                     sticky_r;
    logic                     type_r;
    logic [31:0]              result_r;
    logic [3:0]               flags_r;

    logic [22:0]              rnd_frac_in;
    logic                     rnd_guard;
    logic                     rnd_sticky;
    logic [22:0]              rnd_frac;
    logic                     rnd_carry;
    logic                     rnd_inexact;
    logic signed [EXP_W-1:0]  exp_rounded;
    logic signed [EXP_W-1:0]  emax_v;
    logic [31:0]              round_result;
    logic [3:0]               round_flags;

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = result_r;
    assign bus.out_flags  = flags_r;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: zero mantissa skips NORM; NORM exits once bits [OVF:HID] read 01.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid) next_state = (bus.in_mant == '0) ? ROUND : NORM;
            NORM:    if (mant_r[OVF:HID] == 2'b01) next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Slice fraction/guard/sticky for the selected format and build the packed result and flags.
    always_comb begin
        if (type_r == FLOAT_SINGLE) begin
            rnd_frac_in = mant_r[FTOP -: 23];
            rnd_guard   = mant_r[FTOP-23];
            rnd_sticky  = sticky_r | (|mant_r[FTOP-24:0]);
            emax_v      = EMAX_S;
        end else begin
            rnd_frac_in = {13'd0, mant_r[FTOP -: 10]};
            rnd_guard   = mant_r[FTOP-10];
            rnd_sticky  = sticky_r | (|mant_r[FTOP-11:0]);
            emax_v      = EMAX_H;
        end

        exp_rounded  = exp_r + {{(EXP_W-1){1'b0}}, rnd_carry};
        round_flags  = '0;
        round_flags[FLAG_N] = sign_r;

        if (mant_r == '0) begin
            round_result        = (type_r == FLOAT_SINGLE) ? {sign_r, 31'd0} : {16'd0, sign_r, 15'd0};
            round_flags[FLAG_Z] = 1'b1;
        end else if (exp_rounded >= emax_v) begin
            round_result        = (type_r == FLOAT_SINGLE) ? {sign_r, 31'h7F80_0000} : {16'd0, sign_r, 15'h7C00};
            round_flags[FLAG_V] = 1'b1;
        end else if (exp_rounded[EXP_W-1] || exp_rounded == '0) begin
            round_result        = (type_r == FLOAT_SINGLE) ? {sign_r, 31'd0} : {16'd0, sign_r, 15'd0};
            round_flags[FLAG_Z] = 1'b1;
            round_flags[FLAG_C] = 1'b1;
        end else begin
            round_result        = (type_r == FLOAT_SINGLE) ?
                                  {sign_r, exp_rounded[7:0], rnd_frac} :
                                  {16'd0, sign_r, exp_rounded[4:0], rnd_frac[9:0]};
            round_flags[FLAG_C] = rnd_inexact;
        end
    end

    fpu_rounder u_rounder (
        .frac     (rnd_frac_in),
        .guard    (rnd_guard),
        .sticky   (rnd_sticky),
        .ftype    (type_r),
        .frac_out (rnd_frac),
        .carry    (rnd_carry),
        .inexact  (rnd_inexact)
    );

    // Datapath: capture on accept, one normalize shift per NORM cycle, latch result in ROUND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_r   <= 1'b0;
            exp_r    <= '0;
            mant_r   <= '0;
            sticky_r <= 1'b0;
            type_r   <= 1'b0;
            result_r <= '0;
            flags_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r   <= bus.in_sign;
                        exp_r    <= bus.in_exp;
                        mant_r   <= bus.in_mant;
                        type_r   <= bus.in_type;
                        sticky_r <= 1'b0;
                    end
                end
                NORM: begin
                    if (mant_r[OVF]) begin
                        mant_r   <= mant_r >> 1;
                        exp_r    <= exp_r + 1'b1;
                        sticky_r <= sticky_r | mant_r[0];
                    end else if (!mant_r[HID]) begin
                        mant_r   <= mant_r << 1;
                        exp_r    <= exp_r - 1'b1;
                    end
                end
                ROUND: begin
                    result_r <= round_result;
                    flags_r  <= round_flags;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_normalizer.sv
// Self-checking bench for fpu_normalizer: directed vector table, backpressure
// and mid-operation reset sequences, then randomized operands against a
// value-level reference model. Expectations follow FPU_NORM_RNE_EN.
module tb_fpu_normalizer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fpu_normalizer_if #(.MANT_W(48), .EXP_W(10)) bus ();

    fpu_normalizer #(.MANT_W(48), .EXP_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sign;
        int          exp;
        logic [47:0] mant;
        bit          ftype;
        logic [31:0] result;
        logic [3:0]  flags;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Value-level reference: locate the leading one, scale in one step, round, classify.
    function automatic void ref_model(input bit s, input int e, input logic [47:0] m, input bit t,
                                      output logic [31:0] r, output logic [3:0] f, output int lat);
        int p;
        int ee;
        int fw;
        longint unsigned v;
        longint unsigned frac;
        bit g;
        bit st;
        fw = t ? 23 : 10;
        r = '0;
        f = '0;
        if (m == '0) begin
            r   = t ? {s, 31'd0} : {16'd0, s, 15'd0};
            f   = {s, 1'b1, 2'b00};
            lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        ee = e + p - 46;
        st = 1'b0;
        if (p == 47) begin
            st  = m[0];
            v   = 64'(m) >> 1;
            lat = 3;
        end else begin
            v   = 64'(m) << (46 - p);
            lat = 46 - p + 2;
        end
        frac = (v >> (46 - fw)) & ((64'd1 << fw) - 1);
        g    = v[45 - fw];
        st   = st | ((v & ((64'd1 << (45 - fw)) - 1)) != 0);
`ifdef FPU_NORM_RNE_EN
        if (g && (st || frac[0])) frac = frac + 1;
        if (frac == (64'd1 << fw)) begin
            frac = 0;
            ee   = ee + 1;
        end
`endif
        if (ee >= (t ? 255 : 31)) begin
            r = t ? {s, 31'h7F80_0000} : {16'd0, s, 15'h7C00};
            f = {s, 3'b001};
        end else if (ee <= 0) begin
            r = t ? {s, 31'd0} : {16'd0, s, 15'd0};
            f = {s, 3'b110};
        end else begin
            r = t ? {s, 8'(ee), 23'(frac)} : {16'd0, s, 5'(ee), 10'(frac)};
            f = {s, 1'b0, g | st, 1'b0};
        end
    endfunction

    // Drive one operation, measure latency, check result, optionally stall, then drain.
    task automatic apply_stimulus(input bit s, input int e, input logic [47:0] m, input bit t,
                                  input logic [31:0] want_r, input logic [3:0] want_f,
                                  input int want_lat, input int stall, input string name);
        int lat;
        logic [31:0] held_r;
        logic [3:0]  held_f;
        @(negedge clk);
        bus.in_sign  = s;
        bus.in_exp   = 10'(e);
        bus.in_mant  = m;
        bus.in_type  = t;
        bus.in_valid = 1'b1;
        check_output({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: out_valid never rose, waited %0d cycles", name, lat);
            return;
        end
        check_output({name, " latency"}, 32'(lat), 32'(want_lat));
        check_output({name, " result"}, bus.out_result, want_r);
        check_output({name, " flags"}, 32'(bus.out_flags), 32'(want_f));
        held_r = bus.out_result;
        held_f = bus.out_flags;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("%s stall%0d valid", name, i), 32'(bus.out_valid), 32'd1);
            check_output($sformatf("%s stall%0d result", name, i), bus.out_result, want_r);
            check_output($sformatf("%s stall%0d flags", name, i), 32'(bus.out_flags), 32'(want_f));
            check_output($sformatf("%s stall%0d in_ready", name, i), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_output({name, " drain valid"}, 32'(bus.out_valid), 32'd0);
        check_output({name, " drain in_ready"}, 32'(bus.in_ready), 32'd1);
        check_output({name, " drain result kept"}, {bus.out_flags, bus.out_result[27:0]},
                     {held_f, held_r[27:0]});
    endtask

    initial begin
        logic [31:0] rr;
        logic [3:0]  rf;
        int          rl;
        bit          rs;
        bit          rt;
        int          re;
        logic [47:0] rm;
        logic [63:0] wide;
        logic [31:0] rne_expect;

        checks   = 0;
        failures = 0;
`ifdef FPU_NORM_RNE_EN
        rne_expect = 32'h4000_0000;
`else
        rne_expect = 32'h3FFF_FFFF;
`endif
        vecs[0]  = '{0, 127, 48'h9000_0000_0000, 1, 32'h4010_0000, 4'b0000, 3,  "mul_1p5sq"};
        vecs[1]  = '{0, 15,  48'h4000_0000_0000, 0, 32'h0000_3C00, 4'b0000, 2,  "half_one"};
        vecs[2]  = '{1, 300, 48'h4000_0000_0000, 1, 32'hFF80_0000, 4'b1001, 2,  "single_ovf"};
        vecs[3]  = '{1, -5,  48'h4000_0000_0000, 1, 32'h8000_0000, 4'b1110, 2,  "single_flush"};
        vecs[4]  = '{0, 127, 48'h7FFF_FFC0_0000, 1, rne_expect,    4'b0010, 2,  "round_carry"};
        vecs[5]  = '{0, 50,  48'h0,              1, 32'h0000_0000, 4'b0100, 1,  "zero_single"};
        vecs[6]  = '{1, 7,   48'h0,              0, 32'h0000_8000, 4'b1100, 1,  "negzero_half"};
        vecs[7]  = '{0, 31,  48'h4000_0000_0000, 0, 32'h0000_7C00, 4'b0001, 2,  "half_emax"};
        vecs[8]  = '{0, 30,  48'h4000_0000_0000, 0, 32'h0000_7800, 4'b0000, 2,  "half_maxnorm"};
        vecs[9]  = '{0, 1,   48'h4000_0000_0000, 1, 32'h0080_0000, 4'b0000, 2,  "single_minnorm"};
        vecs[10] = '{0, 0,   48'h4000_0000_0000, 1, 32'h0000_0000, 4'b0110, 2,  "single_exp0"};
        vecs[11] = '{0, 200, 48'h0000_0000_0001, 1, 32'h4D00_0000, 4'b0000, 48, "max_shift"};
        vecs[12] = '{0, 15,  48'hC000_0000_0001, 0, 32'h0000_4200, 4'b0010, 3,  "half_rshift_sticky"};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_type   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset result", bus.out_result, 32'd0);
        check_output("reset flags", 32'(bus.out_flags), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].sign, vecs[i].exp, vecs[i].mant, vecs[i].ftype,
                           vecs[i].result, vecs[i].flags, vecs[i].lat, 0, vecs[i].name);
        end

        // Backpressure: hold out_ready low five cycles in DONE.
        apply_stimulus(0, 127, 48'h9000_0000_0000, 1, 32'h4010_0000, 4'b0000, 3, 5, "backpressure");

        // Reset during a long NORM phase clears outputs asynchronously.
        @(negedge clk);
        bus.in_sign  = 1'b1;
        bus.in_exp   = 10'd200;
        bus.in_mant  = 48'h1;
        bus.in_type  = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check_output("pre-reset in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check_output("async reset in_ready", 32'(bus.in_ready), 32'd1);
        check_output("async reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("async reset result", bus.out_result, 32'd0);
        check_output("async reset flags", 32'(bus.out_flags), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(0, 127, 48'h9000_0000_0000, 1, 32'h4010_0000, 4'b0000, 3, 0, "after_reset");

        // Randomized operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            rs   = 1'($urandom_range(0, 1));
            rt   = 1'($urandom_range(0, 1));
            re   = int'($urandom_range(0, 360)) - 40;
            wide = {$urandom, $urandom};
            rm   = ($urandom_range(0, 9) == 0) ? 48'h0 : 48'(wide >> $urandom_range(16, 63));
            ref_model(rs, re, rm, rt, rr, rf, rl);
            apply_stimulus(rs, re, rm, rt, rr, rf, rl, int'($urandom_range(0, 1)),
                           $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
